reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Integer register file with an in-order write scoreboard. Sits directly downstream of the instruction decoder.
- Consumes the decoder's rs1/rs2/rd fields and returns source operands to execute.
- Tracks registers with a writeback still in flight and raises stall on RAW/WAW hazards.
- Accepts writebacks from the last pipeline stage.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers, x0 included.
- AW, 5, register address width; must equal clog2(NREG).

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs1_addr  in  AW  source register 1 index from decode.
- rs2_addr  in  AW  source register 2 index from decode.
- issue_valid  in  1  decoded instruction presented this cycle.
- issue_wr  in  1  presented instruction writes rd.
- issue_rd  in  AW  destination index from decode.
- wb_en  in  1  writeback valid.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback value.
- rs1_data  out  XLEN  operand 1, combinational.
- rs2_data  out  XLEN  operand 2, combinational.
- stall  out  1  issue blocked this cycle, combinational.
- wb_orphan  out  1  registered 1-cycle pulse: writeback to a register that was not busy.
- busy_cnt  out  AW+1  number of busy registers, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers cleared to 0; all busy bits cleared.
  - wb_orphan=0, busy_cnt=0.
  - rs1_data and rs2_data therefore read 0.
  - Reset mid-operation discards every in-flight busy bit.
- x0:
  - Always reads 0 and is never busy.
  - Writebacks and issues to x0 have no effect on the array or the scoreboard.
  - A writeback to x0 does not raise wb_orphan.
- Read: rs*_data = regs[rs*_addr], combinational, zero-cycle latency.
- Hazard check, where busy_eff[r] is defined under Optional Feature:
  - stall = issue_valid & (busy_eff[rs1_addr] | busy_eff[rs2_addr] | (issue_wr & busy_eff[issue_rd])).
  - Index 0 never contributes to stall.
  - rs2 is always checked; decode marks unused rs2 as x0.
- Issue:
  - Accepted when issue_valid & !stall.
  - If also issue_wr & issue_rd!=0, busy[issue_rd] is set at the next edge.
- Writeback:
  - When wb_en & wb_rd!=0: regs[wb_rd]<=wb_data and busy[wb_rd]<=0 at the edge.
  - If busy[wb_rd] was 0, wb_orphan pulses high for the following cycle. The write is still performed.
- Simultaneous set and clear of the same register in one cycle: set wins, so busy stays 1.
- busy_cnt:
  - Updated at the same edge as the busy vector and equals its popcount.
  - Range 0..NREG-1; it never wraps.
- Latency:
  - Read: 0 cycles.
  - Issue to busy visible: 1 cycle.
  - Writeback to data visible in the array: 1 cycle.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - busy_eff[r] = busy[r] & !(wb_en & wb_rd==r).
  - rs*_data returns wb_data when wb_en & wb_rd==rs*_addr & rs*_addr!=0.
  - A dependent instruction issues in the same cycle as its producer's writeback.
- Undefined:
  - busy_eff = busy.
  - Reads return array contents only.
  - A dependent instruction stalls until the cycle after its producer's writeback.

Decomposition:
- Shared package holds:
  - XLEN, NREG, AW constants.
  - A regidx_t typedef (AW bits) and a word_t typedef (XLEN bits).
  - A REG_ZERO constant (index 0).
- One sub-module, reg_scoreboard, holds the busy vector, set/clear priority, busy_cnt and wb_orphan.
- reg_file_sb instantiates reg_scoreboard and keeps the data array and read muxes.

Test Plan:
1. Reset, then wb_en wb_rd=5 wb_data=0xDEADBEEF -> next cycle rs1_addr=5 gives rs1_data=0xDEADBEEF and wb_orphan=1 for one cycle.
2. Write 0x1234 to x0, then read x0 -> rs1_data=0; wb_orphan stays 0; busy_cnt stays 0.
3. Issue rd=7, then present rs1_addr=7 -> stall=1 and busy_cnt=1.
   - Writeback x7=0x55 -> without bypass, stall drops the following cycle with rs1_data=0x55.
   - With REGFILE_WB_BYPASS_EN, stall=0 in the writeback cycle and rs1_data=0x55.
4. Issue rd=3 in the same cycle as writeback wb_rd=3 (bypass build, x3 busy) -> busy[3] remains 1 and busy_cnt is unchanged.
5. Issue rd=9 and rd=10, so busy_cnt=2, then drive reset=0 mid-cycle -> immediately busy_cnt=0, stall=0, and all reads return 0.
6. x12 busy, issue_valid with issue_wr=1 issue_rd=12 and clean sources -> stall=1 (WAW). Same with issue_wr=0 -> stall=0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared types and constants for the reg_file_sb register file and its write scoreboard.
// Optional feature macro used by this slice: REGFILE_WB_BYPASS_EN.
package reg_file_sb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = AW + 1;

    typedef logic [AW-1:0]   regidx_t;
    typedef logic [XLEN-1:0] word_t;
    typedef logic [CW-1:0]   cnt_t;
    typedef logic [NREG-1:0] regmask_t;

    localparam regidx_t REG_ZERO = '0;

    // Number of set bits in a register mask
    function automatic cnt_t popcount(input regmask_t v);
        cnt_t c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode, writeback and operand signals between the decoder/writeback stage and reg_file_sb.
interface reg_file_sb_if;
    import reg_file_sb_pkg::*;

    regidx_t rs1_addr;
    regidx_t rs2_addr;
    logic    issue_valid;
    logic    issue_wr;
    regidx_t issue_rd;
    logic    wb_en;
    regidx_t wb_rd;
    word_t   wb_data;
    word_t   rs1_data;
    word_t   rs2_data;
    logic    stall;
    logic    wb_orphan;
    cnt_t    busy_cnt;

    // Decoder / writeback side
    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_wr, issue_rd,
        output wb_en, wb_rd, wb_data,
        input  rs1_data, rs2_data, stall, wb_orphan, busy_cnt
    );

    // Register file side
    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_wr, issue_rd,
        input  wb_en, wb_rd, wb_data,
        output rs1_data, rs2_data, stall, wb_orphan, busy_cnt
    );

endinterface

// File: rtl/reg_scoreboard.sv
// In-order write scoreboard: busy vector, RAW/WAW stall, busy count and orphan-writeback pulse.
// With REGFILE_WB_BYPASS_EN a register being written back this cycle no longer counts as busy.
module reg_scoreboard
    import reg_file_sb_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    issue_valid,
    input  logic    issue_wr,
    input  regidx_t issue_rd,
    input  regidx_t rs1_addr,
    input  regidx_t rs2_addr,
    input  logic    wb_en,
    input  regidx_t wb_rd,
    output logic    stall,
    output logic    wb_orphan,
    output cnt_t    busy_cnt
);

    regmask_t busy;
    regmask_t busy_eff;
    regmask_t busy_nxt;
    logic     set_hit;
    logic     clr_hit;
    logic     orphan_nxt;

    // Busy view used by the hazard check; x0 never contributes
    always_comb begin
        busy_eff = busy;
`ifdef REGFILE_WB_BYPASS_EN
        if (wb_en) begin
            busy_eff[wb_rd] = 1'b0;
        end
`endif
        busy_eff[REG_ZERO] = 1'b0;
    end

    always_comb begin
        stall = issue_valid & (busy_eff[rs1_addr] | busy_eff[rs2_addr]
                               | (issue_wr & busy_eff[issue_rd]));
    end

    // Clear from writeback first, then set from issue so a same-cycle set wins
    always_comb begin
        clr_hit    = wb_en && (wb_rd != REG_ZERO);
        set_hit    = issue_valid && !stall && issue_wr && (issue_rd != REG_ZERO);
        orphan_nxt = clr_hit && !busy[wb_rd];
        busy_nxt   = busy;
        if (clr_hit) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (set_hit) begin
            busy_nxt[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= '0;
            busy_cnt  <= '0;
            wb_orphan <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            busy_cnt  <= popcount(busy_nxt);
            wb_orphan <= orphan_nxt;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with in-order write scoreboard, fed by decode and the writeback stage.
// Define REGFILE_WB_BYPASS_EN to forward writeback data to the read ports and hazard check.
module reg_file_sb
    import reg_file_sb_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    reg_file_sb_if.slave bus
);

    word_t regs [NREG];
    word_t rs1_val;
    word_t rs2_val;
    logic  stall_w;
    logic  orphan_w;
    cnt_t  cnt_w;

    reg_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (bus.issue_valid),
        .issue_wr    (bus.issue_wr),
        .issue_rd    (bus.issue_rd),
        .rs1_addr    (bus.rs1_addr),
        .rs2_addr    (bus.rs2_addr),
        .wb_en       (bus.wb_en),
        .wb_rd       (bus.wb_rd),
        .stall       (stall_w),
        .wb_orphan   (orphan_w),
        .busy_cnt    (cnt_w)
    );

    // Data array; x0 is never written so it always reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_rd != REG_ZERO)) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Zero-latency read ports
    always_comb begin
        rs1_val = regs[bus.rs1_addr];
        rs2_val = regs[bus.rs2_addr];
`ifdef REGFILE_WB_BYPASS_EN
        if (bus.wb_en && (bus.wb_rd == bus.rs1_addr) && (bus.rs1_addr != REG_ZERO)) begin
            rs1_val = bus.wb_data;
        end
        if (bus.wb_en && (bus.wb_rd == bus.rs2_addr) && (bus.rs2_addr != REG_ZERO)) begin
            rs2_val = bus.wb_data;
        end
`endif
    end

    assign bus.rs1_data  = rs1_val;
    assign bus.rs2_data  = rs2_val;
    assign bus.stall     = stall_w;
    assign bus.wb_orphan = orphan_w;
    assign bus.busy_cnt  = cnt_w;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; expectations follow REGFILE_WB_BYPASS_EN when defined.
module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    reg_file_sb_if bus ();

    reg_file_sb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_wr    = 1'b0;
        bus.issue_rd    = '0;
        bus.wb_en       = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        clear_inputs();
        tick();
        tick();
        chk_eq("rst_cnt", 64'(bus.busy_cnt), 64'd0);
        chk_eq("rst_orphan", 64'(bus.wb_orphan), 64'd0);
        chk_eq("rst_stall", 64'(bus.stall), 64'd0);
        chk_eq("rst_rs1", 64'(bus.rs1_data), 64'd0);
        reset = 1'b1;
        tick();

        // 1: orphan writeback to x5, visible next cycle
        bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
        tick();
        bus.wb_en = 1'b0; bus.rs1_addr = 5'd5;
        #1;
        chk_eq("t1_rs1", 64'(bus.rs1_data), 64'hDEADBEEF);
        chk_eq("t1_orphan", 64'(bus.wb_orphan), 64'd1);
        tick();
        chk_eq("t1_orphan_drop", 64'(bus.wb_orphan), 64'd0);

        // 2: x0 writes and issues have no effect
        bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h1234;
        bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd0;
        tick();
        clear_inputs();
        #1;
        chk_eq("t2_rs1", 64'(bus.rs1_data), 64'd0);
        chk_eq("t2_orphan", 64'(bus.wb_orphan), 64'd0);
        chk_eq("t2_cnt", 64'(bus.busy_cnt), 64'd0);

        // 3: RAW on x7 resolved by writeback
        bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd7;
        #1;
        chk_eq("t3_issue_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.issue_wr = 1'b0; bus.rs1_addr = 5'd7;
        #1;
        chk_eq("t3_raw_stall", 64'(bus.stall), 64'd1);
        chk_eq("t3_cnt", 64'(bus.busy_cnt), 64'd1);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h55;
        #1;
        chk_eq("t3_wb_stall", 64'(bus.stall), BYP ? 64'd0 : 64'd1);
        chk_eq("t3_wb_rs1", 64'(bus.rs1_data), BYP ? 64'h55 : 64'd0);
        tick();
        bus.wb_en = 1'b0;
        #1;
        chk_eq("t3_after_stall", 64'(bus.stall), 64'd0);
        chk_eq("t3_after_rs1", 64'(bus.rs1_data), 64'h55);
        chk_eq("t3_after_cnt", 64'(bus.busy_cnt), 64'd0);
        chk_eq("t3_after_orphan", 64'(bus.wb_orphan), 64'd0);
        clear_inputs();

        // 4: issue rd=3 alongside writeback of busy x3
        bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd3;
        tick();
        chk_eq("t4_cnt_set", 64'(bus.busy_cnt), 64'd1);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h33;
        #1;
        chk_eq("t4_stall", 64'(bus.stall), BYP ? 64'd0 : 64'd1);
        tick();
        bus.issue_valid = 1'b0; bus.issue_wr = 1'b0; bus.wb_en = 1'b0; bus.rs1_addr = 5'd3;
        #1;
        chk_eq("t4_cnt_same", 64'(bus.busy_cnt), BYP ? 64'd1 : 64'd0);
        chk_eq("t4_orphan", 64'(bus.wb_orphan), 64'd0);
        chk_eq("t4_rs1", 64'(bus.rs1_data), 64'h33);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h34;
        tick();
        bus.wb_en = 1'b0;
        #1;
        chk_eq("t4_orphan2", 64'(bus.wb_orphan), BYP ? 64'd0 : 64'd1);
        chk_eq("t4_cnt_clr", 64'(bus.busy_cnt), 64'd0);
        chk_eq("t4_rs1_2", 64'(bus.rs1_data), 64'h34);
        clear_inputs();

        // 6: WAW on x12 and rs2 RAW
        bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd12;
        tick();
        #1;
        chk_eq("t6_waw", 64'(bus.stall), 64'd1);
        bus.issue_wr = 1'b0;
        #1;
        chk_eq("t6_nowr", 64'(bus.stall), 64'd0);
        bus.rs2_addr = 5'd12;
        #1;
        chk_eq("t6_rs2_raw", 64'(bus.stall), 64'd1);
        bus.issue_valid = 1'b0;
        #1;
        chk_eq("t6_novalid", 64'(bus.stall), 64'd0);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd12; bus.wb_data = 32'hA5;
        tick();
        bus.wb_en = 1'b0;
        #1;
        chk_eq("t6_cnt_clr", 64'(bus.busy_cnt), 64'd0);
        chk_eq("t6_rs2", 64'(bus.rs2_data), 64'hA5);
        clear_inputs();

        // 5: two in flight, then asynchronous reset mid-cycle
        bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd9;
        tick();
        bus.issue_rd = 5'd10;
        tick();
        bus.issue_valid = 1'b0; bus.issue_wr = 1'b0;
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd12;
        #1;
        chk_eq("t5_cnt2", 64'(bus.busy_cnt), 64'd2);
        chk_eq("t5_rs1_pre", 64'(bus.rs1_data), 64'hDEADBEEF);
        #1;
        reset = 1'b0;
        #1;
        chk_eq("t5_rst_cnt", 64'(bus.busy_cnt), 64'd0);
        chk_eq("t5_rst_rs1", 64'(bus.rs1_data), 64'd0);
        chk_eq("t5_rst_rs2", 64'(bus.rs2_data), 64'd0);
        bus.issue_valid = 1'b1; bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd10;
        #1;
        chk_eq("t5_rst_stall", 64'(bus.stall), 64'd0);
        reset = 1'b1;
        tick();
        chk_eq("t5_post_stall", 64'(bus.stall), 64'd0);
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
